escalonador_ticks: RTL and testbench

- Replaces the ripple-clock divider chain with one synchronous tick scheduler for the elevator system.
- From the single board clock it generates one-cycle enable pulses for three consumers:
  - motor/floor stepping (~0.75 Hz default)
  - button debounce sampling
  - 7-segment display multiplex select
- Each channel's period is runtime-configurable through a valid/ready port.
- Provides a door-open timer counted in motor ticks.

---
 rtl/escalonador_ticks.sv | 170 +++++++++++++++++
 tb/tb_escalonador_ticks.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_ticks.sv
// Tick scheduler: three one-cycle enable channels with runtime periods,
// a shared single-slot config port, and a door timer counted in motor ticks.
module escalonador_ticks #(
  parameter int          CNT_W     = 26,
  parameter int unsigned DEF_MOTOR = 67108863,
  parameter int unsigned DEF_DEB   = 524287,
  parameter int unsigned DEF_DISP  = 2047,
  parameter int          TIMER_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_sel,
  input  logic [CNT_W-1:0]   cfg_data,
  input  logic               motor_pause,
  input  logic               timer_start,
  input  logic [TIMER_W-1:0] timer_len,
  output logic               timer_busy,
  output logic               timer_done,
  output logic               tick_motor,
  output logic               tick_debounce,
  output logic [1:0]         display_sel
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } tmr_st_t;

  logic [CNT_W-1:0]   r_per_m, r_per_d, r_per_s;
  logic [CNT_W-1:0]   r_cnt_m, r_cnt_d, r_cnt_s;
  logic               r_tick_m, r_tick_d;
  logic [1:0]         r_disp;
  logic               r_pend_vld;
  logic [1:0]         r_pend_sel;
  logic [CNT_W-1:0]   r_pend_data;
  tmr_st_t            r_st;
  logic [TIMER_W-1:0] r_rem;
  logic               r_done;

  logic               w_wrap_m, w_wrap_d, w_wrap_s;
  logic               w_apply_m, w_apply_d, w_apply_s;
  logic               w_keep;
  tmr_st_t            w_st_nxt;
  logic [TIMER_W-1:0] w_rem_nxt;
  logic               w_done_nxt;

  // Motor wrap is suppressed while paused, which also blocks its apply.
  assign w_wrap_m  = ~motor_pause && (r_cnt_m == r_per_m);
  assign w_wrap_d  = (r_cnt_d == r_per_d);
  assign w_wrap_s  = (r_cnt_s == r_per_s);
  assign w_apply_m = w_wrap_m && r_pend_vld && (r_pend_sel == 2'd0);
  assign w_apply_d = w_wrap_d && r_pend_vld && (r_pend_sel == 2'd1);
  assign w_apply_s = w_wrap_s && r_pend_vld && (r_pend_sel == 2'd2);
  assign w_keep    = cfg_valid && ~r_pend_vld && (cfg_sel != 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_sel  <= 2'd0;
      r_pend_data <= '0;
    end else if (w_apply_m || w_apply_d || w_apply_s) begin
      r_pend_vld  <= 1'b0;
    end else if (w_keep) begin
      r_pend_vld  <= 1'b1;
      r_pend_sel  <= cfg_sel;
      r_pend_data <= cfg_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_per_m  <= CNT_W'(DEF_MOTOR);
      r_cnt_m  <= '0;
      r_tick_m <= 1'b0;
    end else if (motor_pause) begin
      r_tick_m <= 1'b0;
    end else if (w_wrap_m) begin
      r_cnt_m  <= '0;
      r_tick_m <= 1'b1;
      if (w_apply_m) r_per_m <= r_pend_data;
    end else begin
      r_cnt_m  <= r_cnt_m + CNT_W'(1);
      r_tick_m <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_per_d  <= CNT_W'(DEF_DEB);
      r_cnt_d  <= '0;
      r_tick_d <= 1'b0;
    end else if (w_wrap_d) begin
      r_cnt_d  <= '0;
      r_tick_d <= 1'b1;
      if (w_apply_d) r_per_d <= r_pend_data;
    end else begin
      r_cnt_d  <= r_cnt_d + CNT_W'(1);
      r_tick_d <= 1'b0;
    end
  end

  // The display tick only advances the digit select.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_per_s <= CNT_W'(DEF_DISP);
      r_cnt_s <= '0;
      r_disp  <= 2'd0;
    end else if (w_wrap_s) begin
      r_cnt_s <= '0;
      r_disp  <= r_disp + 2'd1;
      if (w_apply_s) r_per_s <= r_pend_data;
    end else begin
      r_cnt_s <= r_cnt_s + CNT_W'(1);
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_rem_nxt  = r_rem;
    w_done_nxt = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (timer_start) begin
          if (timer_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_st_nxt  = S_RUN;
            w_rem_nxt = timer_len;
          end
        end
      end
      S_RUN: begin
        if (r_tick_m) begin
          if (r_rem == TIMER_W'(1)) begin
            w_st_nxt   = S_IDLE;
            w_rem_nxt  = '0;
            w_done_nxt = 1'b1;
          end else begin
            w_rem_nxt = r_rem - TIMER_W'(1);
          end
        end
      end
      default: begin
        w_st_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st   <= S_IDLE;
      r_rem  <= '0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_rem  <= w_rem_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign cfg_ready     = ~r_pend_vld;
  assign timer_busy    = (r_st == S_RUN);
  assign timer_done    = r_done;
  assign tick_motor    = r_tick_m;
  assign tick_debounce = r_tick_d;
  assign display_sel   = r_disp;

endmodule

// File: tb/tb_escalonador_ticks.sv
// Directed bench for escalonador_ticks; expected values queued at stimulus
// time and popped when the DUT event is observed.
module tb_escalonador_ticks;

  localparam int CNT_W   = 26;
  localparam int TIMER_W = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_sel = 2'd0;
  logic [CNT_W-1:0]   cfg_data = '0;
  logic               motor_pause = 1'b0;
  logic               timer_start = 1'b0;
  logic [TIMER_W-1:0] timer_len = '0;
  logic               timer_busy;
  logic               timer_done;
  logic               tick_motor;
  logic               tick_debounce;
  logic [1:0]         display_sel;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          t0, tt, at, rr, busy_n;
  logic        seen;

  // Short motor/debounce defaults keep the run small; display keeps its default.
  escalonador_ticks #(
    .CNT_W(CNT_W), .DEF_MOTOR(29), .DEF_DEB(999),
    .DEF_DISP(2047), .TIMER_W(TIMER_W)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .motor_pause(motor_pause),
    .timer_start(timer_start), .timer_len(timer_len),
    .timer_busy(timer_busy), .timer_done(timer_done),
    .tick_motor(tick_motor), .tick_debounce(tick_debounce),
    .display_sel(display_sel)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s obs=%0d exp=none", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s obs=%0d exp=%0d", tag, obs, e);
      end
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return tick_motor;
      1:       return tick_debounce;
      2:       return timer_done;
      3:       return display_sel == 2'd1;
      default: return display_sel == 2'd0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (sig(which)) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    exp_q.push_back(1); chk({tag, "_ready"}, 32'(cfg_ready));
    exp_q.push_back(0); chk({tag, "_tm"}, 32'(tick_motor));
    exp_q.push_back(0); chk({tag, "_td"}, 32'(tick_debounce));
    exp_q.push_back(0); chk({tag, "_disp"}, 32'(display_sel));
    exp_q.push_back(0); chk({tag, "_busy"}, 32'(timer_busy));
    exp_q.push_back(0); chk({tag, "_done"}, 32'(timer_done));
  endtask

  initial begin
    // reset state and default periods
    repeat (3) @(negedge clock);
    chk_idle("rst");
    reset = 1'b1;
    t0 = cyc;
    exp_q.push_back(30);
    wait_sig(0, 40, at);   chk("m_first", 32'(at - t0));
    exp_q.push_back(1000);
    wait_sig(1, 1100, at); chk("deb_first", 32'(at - t0));
    exp_q.push_back(2048);
    wait_sig(3, 2100, at); chk("disp_1", 32'(at - t0));
    exp_q.push_back(8192);
    wait_sig(4, 6200, at); chk("disp_wrap", 32'(at - t0));

    // motor reconfig mid-period
    wait_sig(0, 40, tt);
    repeat (3) @(negedge clock);
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 9;
    @(negedge clock);
    cfg_valid = 1'b0;
    exp_q.push_back(0);  chk("ready_pend", 32'(cfg_ready));
    exp_q.push_back(30);
    wait_sig(0, 40, at); chk("m_old_per", 32'(at - tt));
    exp_q.push_back(1);  chk("ready_back", 32'(cfg_ready));
    tt = at; exp_q.push_back(10);
    wait_sig(0, 20, at); chk("m_p9_a", 32'(at - tt));
    tt = at; exp_q.push_back(10);
    wait_sig(0, 20, at); chk("m_p9_b", 32'(at - tt));

    // pause at count 2 with a pending update
    tt = at;
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 4;
    @(negedge clock);
    cfg_valid = 1'b0;
    exp_q.push_back(10);
    wait_sig(0, 20, at); chk("m_to_p4", 32'(at - tt));
    tt = at; exp_q.push_back(5);
    wait_sig(0, 20, at); chk("m_p4", 32'(at - tt));
    repeat (2) @(negedge clock);
    motor_pause = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 6;
    seen = 1'b0;
    repeat (7) begin
      @(negedge clock);
      cfg_valid = 1'b0;
      seen = seen | tick_motor;
    end
    exp_q.push_back(0); chk("pause_notick", 32'(seen));
    exp_q.push_back(0); chk("pause_pend", 32'(cfg_ready));
    motor_pause = 1'b0;
    rr = cyc;
    exp_q.push_back(3);
    wait_sig(0, 20, at); chk("m_resume", 32'(at - rr));
    exp_q.push_back(1);  chk("ready_postpause", 32'(cfg_ready));
    tt = at; exp_q.push_back(7);
    wait_sig(0, 20, at); chk("m_p6", 32'(at - tt));

    // door timer, started on a tick cycle, restart ignored
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 4;
    @(negedge clock);
    cfg_valid = 1'b0;
    wait_sig(0, 20, tt);
    timer_start = 1'b1; timer_len = 3;
    @(negedge clock);
    timer_start = 1'b0;
    exp_q.push_back(1); chk("t_busy", 32'(timer_busy));
    busy_n = 1; at = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin
        timer_start = 1'b1; timer_len = 1;
      end
      @(negedge clock);
      timer_start = 1'b0;
      if (timer_done) begin
        at = cyc;
        break;
      end
      busy_n += int'(timer_busy);
    end
    exp_q.push_back(16); chk("t_done_at", 32'(at - tt));
    exp_q.push_back(15); chk("t_busy_cyc", 32'(busy_n));
    exp_q.push_back(0);  chk("t_idle", 32'(timer_busy));
    @(negedge clock);
    exp_q.push_back(0);  chk("t_done_1cyc", 32'(timer_done));

    // zero-length timer, reserved cfg select
    timer_start = 1'b1; timer_len = 0;
    @(negedge clock);
    timer_start = 1'b0;
    exp_q.push_back(1); chk("t0_done", 32'(timer_done));
    exp_q.push_back(0); chk("t0_busy", 32'(timer_busy));
    @(negedge clock);
    exp_q.push_back(0); chk("t0_done_off", 32'(timer_done));
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_data = 1;
    @(negedge clock);
    cfg_valid = 1'b0;
    exp_q.push_back(1); chk("sel3_ready", 32'(cfg_ready));
    wait_sig(0, 20, tt);
    exp_q.push_back(5);
    wait_sig(0, 20, at); chk("sel3_m_a", 32'(at - tt));
    tt = at; exp_q.push_back(5);
    wait_sig(0, 20, at); chk("sel3_m_b", 32'(at - tt));

    // reset during RUN with a pending config
    timer_start = 1'b1; timer_len = 5;
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_data = 2;
    @(negedge clock);
    timer_start = 1'b0; cfg_valid = 1'b0;
    exp_q.push_back(1); chk("r_busy", 32'(timer_busy));
    exp_q.push_back(0); chk("r_pend", 32'(cfg_ready));
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_idle("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    t0 = cyc;
    seen = 1'b0; at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      seen = seen | timer_done;
      if (tick_motor) begin
        at = cyc;
        break;
      end
    end
    exp_q.push_back(30); chk("r_m_default", 32'(at - t0));
    exp_q.push_back(0);  chk("r_no_done", 32'(seen));
    exp_q.push_back(1);  chk("r_ready", 32'(cfg_ready));
    exp_q.push_back(0);  chk("r_busy_off", 32'(timer_busy));
    tt = at; exp_q.push_back(30);
    wait_sig(0, 40, at); chk("r_m_default2", 32'(at - tt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
